// File: rtl/timer16_pkg.sv
// Shared types and defaults for the 16-bit timer sequencer and its counter core.
package timer16_pkg;

   localparam int CW_DEF = 16;   // counter / period width
   localparam int PW_DEF = 8;    // prescaler width

   localparam logic [CW_DEF-1:0] CNT_ZERO = '0;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/timer16_ctrl_cnt16_core.sv
// Plain CW-bit up-counter register: synchronous clear has priority over enable.
module cnt16_core
   import timer16_pkg::*;
#(
   parameter int CW = CW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          i_clr,
   input  logic          i_en,
   output logic [CW-1:0] o_cnt
);

   logic [CW-1:0] r_cnt;

   // Count register: clear beats increment, otherwise hold.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
      if (!rst_n) begin
         r_cnt <= CW'(CNT_ZERO);
      end else if (i_clr) begin
         r_cnt <= CW'(CNT_ZERO);
      end else if (i_en) begin
         r_cnt <= r_cnt + CW'(1);
      end
   end

   assign o_cnt = r_cnt;

endmodule

// File: rtl/timer16_ctrl.sv
// Timer sequencer: FSM, prescaler, shadowed configuration and irq pulse around cnt16_core.
module timer16_ctrl
   import timer16_pkg::*;
#(
   parameter int CW = CW_DEF,
   parameter int PW = PW_DEF
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic [CW-1:0] cfg_period,
   input  logic [PW-1:0] cfg_presc,
   input  logic          cfg_oneshot,
   input  logic          start_i,
   input  logic          stop_i,
   output logic [CW-1:0] cnt_o,
   output logic          busy_o,
   output logic          done_o,
   output logic          irq_o
);

   state_t        r_state;
   state_t        w_next_state;

   logic [PW-1:0] r_presc_cnt;
   logic [CW-1:0] r_sh_period;
   logic [PW-1:0] r_sh_presc;
   logic          r_sh_oneshot;
   logic          r_irq;

   logic [CW-1:0] w_cnt;
   logic          w_tick;       // prescaler reached its terminal value this cycle
   logic          w_tc;         // tick while the counter sits at the terminal count
   logic          w_start_go;   // start request not overridden by a simultaneous stop
   logic          w_cnt_clr;
   logic          w_cnt_en;
   logic          w_load_sh;
   logic          w_irq_set;

   assign w_tick     = (r_state == RUN) && (r_presc_cnt == r_sh_presc);
   assign w_tc       = w_tick && (w_cnt == r_sh_period);
   assign w_start_go = start_i && !stop_i;

   // FSM state register.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_state <= IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // FSM next-state logic: stop beats start, start beats terminal count.
   always_comb begin
      // NOTE: default assignment first so no path through this block infers a latch.
      w_next_state = r_state;
      case (r_state)
         IDLE: begin
            if (w_start_go) w_next_state = RUN;
         end
         RUN: begin
            if (stop_i) begin
               w_next_state = IDLE;
            end else if (start_i) begin
               w_next_state = RUN;
            end else if (w_tc && r_sh_oneshot) begin
               w_next_state = DONE;
            end
         end
         DONE: begin
            if (w_start_go) w_next_state = RUN;
         end
         default: w_next_state = IDLE;
      endcase
   end

   // FSM outputs and datapath controls.
   always_comb begin
      busy_o    = (r_state == RUN);
      done_o    = (r_state == DONE);
      w_cnt_clr = 1'b0;
      w_cnt_en  = 1'b0;
      w_load_sh = 1'b0;
      w_irq_set = 1'b0;
      if (w_start_go) begin
         // (Re)start from any state: zero the count and capture fresh config.
         w_cnt_clr = 1'b1;
         w_load_sh = 1'b1;
      end else if ((r_state == RUN) && !stop_i && !start_i) begin
         if (w_tc) begin
            w_cnt_clr = 1'b1;
            w_load_sh = 1'b1;
            w_irq_set = 1'b1;
         end else if (w_tick) begin
            w_cnt_en = 1'b1;
         end
      end
   end

   // Prescaler: free-runs in RUN, wraps on tick, freezes when stopped.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_presc_cnt <= '0;
      end else if (w_start_go) begin
         r_presc_cnt <= '0;
      end else if ((r_state == RUN) && !stop_i) begin
         if (w_tick) begin
            r_presc_cnt <= '0;
         end else begin
            r_presc_cnt <= r_presc_cnt + PW'(1);
         end
      end
   end

   // Shadow configuration: only sampled at start and at reload.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_sh_period  <= '0;
         r_sh_presc   <= '0;
         r_sh_oneshot <= 1'b0;
      end else if (w_load_sh) begin
         r_sh_period  <= cfg_period;
         r_sh_presc   <= cfg_presc;
         r_sh_oneshot <= cfg_oneshot;
      end
   end

   // One-cycle interrupt pulse, aligned with the count returning to zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_irq <= 1'b0;
      end else begin
         r_irq <= w_irq_set;
      end
   end

   cnt16_core #(
      .CW (CW)
   ) u_cnt (
      .clk   (clk),
      .rst_n (rst_n),
      .i_clr (w_cnt_clr),
      .i_en  (w_cnt_en),
      .o_cnt (w_cnt)
   );

   assign cnt_o = w_cnt;
   assign irq_o = r_irq;

endmodule

// File: tb/tb_timer16_ctrl.sv
// Scoreboard bench for timer16_ctrl: directed stimulus pushes expected per-cycle
// values and irq cycles; a negedge monitor pops and compares them.
module tb_timer16_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [15:0] cfg_period;
   logic [7:0]  cfg_presc;
   logic        cfg_oneshot;
   logic        start_i;
   logic        stop_i;
   logic [15:0] cnt_o;
   logic        busy_o;
   logic        done_o;
   logic        irq_o;

   int cyc = 0;
   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int          cyc;
      logic [15:0] cnt;
      logic        busy;
      logic        done;
      logic        irq;
      string       name;
   } exp_t;

   exp_t exp_q[$];
   int   irq_q[$];

   timer16_ctrl dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .cfg_period  (cfg_period),
      .cfg_presc   (cfg_presc),
      .cfg_oneshot (cfg_oneshot),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .cnt_o       (cnt_o),
      .busy_o      (busy_o),
      .done_o      (done_o),
      .irq_o       (irq_o)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      n_checks++;
      if (act !== req) begin
         n_errors++;
         $display("FAIL %s @cyc %0d: got %0h, expected %0h", name, cyc, act, req);
      end
   endtask

   function automatic void expect_at(input int c, input logic [15:0] cnt, input logic busy,
                                     input logic done, input logic irq, input string name);
      exp_t e;
      e.cyc = c; e.cnt = cnt; e.busy = busy; e.done = done; e.irq = irq; e.name = name;
      exp_q.push_back(e);
   endfunction

   // Monitor: irq events against expected cycles, then any per-cycle expectations due now.
   always @(negedge clk) begin
      exp_t e;
      int   ic;
      while (irq_q.size() != 0 && irq_q[0] < cyc) begin
         ic = irq_q.pop_front();
         check("irq_missed", 32'(0), 32'(ic));
      end
      if (irq_o === 1'b1) begin
         if (irq_q.size() != 0 && irq_q[0] == cyc) begin
            ic = irq_q.pop_front();
            check("irq_cycle", 32'(cyc), 32'(ic));
         end else begin
            check("irq_unexpected", 32'(1), 32'(0));
         end
      end
      while (exp_q.size() != 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         check({e.name, "_missed"}, 32'(cyc), 32'(e.cyc));
      end
      while (exp_q.size() != 0 && exp_q[0].cyc == cyc) begin
         e = exp_q.pop_front();
         check({e.name, "_cnt"},  32'(cnt_o),  32'(e.cnt));
         check({e.name, "_busy"}, 32'(busy_o), 32'(e.busy));
         check({e.name, "_done"}, 32'(done_o), 32'(e.done));
         check({e.name, "_irq"},  32'(irq_o),  32'(e.irq));
      end
   end

   task automatic wait_until(input int c);
      while (cyc < c) begin
         @(posedge clk);
         #1;
      end
   endtask

   // Holds start/stop for exactly one sampled edge.
   task automatic pulse(input logic s, input logic p);
      start_i = s;
      stop_i  = p;
      @(posedge clk);
      #1;
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   task automatic set_cfg(input logic [15:0] per, input logic [7:0] pre, input logic os);
      cfg_period  = per;
      cfg_presc   = pre;
      cfg_oneshot = os;
   endtask

   initial begin
      int b;
      rst_n   = 1'b0;
      start_i = 1'b0;
      stop_i  = 1'b0;
      set_cfg(16'd0, 8'd0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
      expect_at(cyc, 16'd0, 1'b0, 1'b0, 1'b0, "reset_init");
      wait_until(cyc + 2);

      // Periodic: period 3, presc 0.
      set_cfg(16'd3, 8'd0, 1'b0);
      b = cyc;
      expect_at(b + 1,  16'd0, 1'b1, 1'b0, 1'b0, "per_c1");
      expect_at(b + 2,  16'd1, 1'b1, 1'b0, 1'b0, "per_c2");
      expect_at(b + 3,  16'd2, 1'b1, 1'b0, 1'b0, "per_c3");
      expect_at(b + 4,  16'd3, 1'b1, 1'b0, 1'b0, "per_c4");
      expect_at(b + 5,  16'd0, 1'b1, 1'b0, 1'b1, "per_c5");
      expect_at(b + 6,  16'd1, 1'b1, 1'b0, 1'b0, "per_c6");
      expect_at(b + 9,  16'd0, 1'b1, 1'b0, 1'b1, "per_c9");
      expect_at(b + 13, 16'd0, 1'b1, 1'b0, 1'b1, "per_c13");
      expect_at(b + 15, 16'd1, 1'b0, 1'b0, 1'b0, "per_stop");
      irq_q.push_back(b + 5);
      irq_q.push_back(b + 9);
      irq_q.push_back(b + 13);
      pulse(1'b1, 1'b0);
      wait_until(b + 14);
      pulse(1'b0, 1'b1);
      wait_until(b + 17);

      // Prescale: period 1, presc 2.
      set_cfg(16'd1, 8'd2, 1'b0);
      b = cyc;
      expect_at(b + 1,  16'd0, 1'b1, 1'b0, 1'b0, "pre_c1");
      expect_at(b + 3,  16'd0, 1'b1, 1'b0, 1'b0, "pre_c3");
      expect_at(b + 4,  16'd1, 1'b1, 1'b0, 1'b0, "pre_c4");
      expect_at(b + 6,  16'd1, 1'b1, 1'b0, 1'b0, "pre_c6");
      expect_at(b + 7,  16'd0, 1'b1, 1'b0, 1'b1, "pre_c7");
      expect_at(b + 8,  16'd0, 1'b1, 1'b0, 1'b0, "pre_c8");
      expect_at(b + 10, 16'd1, 1'b1, 1'b0, 1'b0, "pre_c10");
      expect_at(b + 13, 16'd0, 1'b1, 1'b0, 1'b1, "pre_c13");
      expect_at(b + 14, 16'd0, 1'b1, 1'b0, 1'b0, "pre_c14");
      expect_at(b + 16, 16'd0, 1'b0, 1'b0, 1'b0, "pre_stop");
      irq_q.push_back(b + 7);
      irq_q.push_back(b + 13);
      pulse(1'b1, 1'b0);
      wait_until(b + 15);
      pulse(1'b0, 1'b1);
      wait_until(b + 18);

      // One-shot: period 2, then restart clears done, then stop in DONE ignored.
      set_cfg(16'd2, 8'd0, 1'b1);
      b = cyc;
      expect_at(b + 3,  16'd2, 1'b1, 1'b0, 1'b0, "os_c3");
      expect_at(b + 4,  16'd0, 1'b0, 1'b1, 1'b1, "os_c4");
      expect_at(b + 5,  16'd0, 1'b0, 1'b1, 1'b0, "os_c5");
      expect_at(b + 8,  16'd0, 1'b0, 1'b1, 1'b0, "os_hold");
      expect_at(b + 9,  16'd0, 1'b1, 1'b0, 1'b0, "os_restart");
      expect_at(b + 11, 16'd2, 1'b1, 1'b0, 1'b0, "os2_c3");
      expect_at(b + 12, 16'd0, 1'b0, 1'b1, 1'b1, "os2_c4");
      expect_at(b + 14, 16'd0, 1'b0, 1'b1, 1'b0, "os_stop_ign");
      irq_q.push_back(b + 4);
      irq_q.push_back(b + 12);
      pulse(1'b1, 1'b0);
      wait_until(b + 8);
      pulse(1'b1, 1'b0);
      wait_until(b + 13);
      pulse(1'b0, 1'b1);
      wait_until(b + 16);

      // Stop/resume, restart in RUN, start&stop together.
      set_cfg(16'd20, 8'd0, 1'b0);
      b = cyc;
      expect_at(b + 6,  16'd5, 1'b1, 1'b0, 1'b0, "ss_at5");
      expect_at(b + 7,  16'd5, 1'b0, 1'b0, 1'b0, "ss_stop");
      expect_at(b + 9,  16'd5, 1'b0, 1'b0, 1'b0, "ss_hold");
      expect_at(b + 10, 16'd0, 1'b1, 1'b0, 1'b0, "ss_start");
      expect_at(b + 12, 16'd2, 1'b1, 1'b0, 1'b0, "ss_run2");
      expect_at(b + 13, 16'd0, 1'b1, 1'b0, 1'b0, "ss_restart");
      expect_at(b + 14, 16'd1, 1'b1, 1'b0, 1'b0, "ss_run1");
      expect_at(b + 15, 16'd1, 1'b0, 1'b0, 1'b0, "ss_both");
      expect_at(b + 16, 16'd1, 1'b0, 1'b0, 1'b0, "ss_both_hold");
      pulse(1'b1, 1'b0);
      wait_until(b + 6);
      pulse(1'b0, 1'b1);
      wait_until(b + 9);
      pulse(1'b1, 1'b0);
      wait_until(b + 12);
      pulse(1'b1, 1'b0);
      wait_until(b + 14);
      pulse(1'b1, 1'b1);
      wait_until(b + 18);

      // Shadow: cfg_period 3 -> 7 mid-run takes effect only at reload.
      set_cfg(16'd3, 8'd0, 1'b0);
      b = cyc;
      expect_at(b + 4,  16'd3, 1'b1, 1'b0, 1'b0, "sh_c4");
      expect_at(b + 5,  16'd0, 1'b1, 1'b0, 1'b1, "sh_c5");
      expect_at(b + 9,  16'd4, 1'b1, 1'b0, 1'b0, "sh_c9");
      expect_at(b + 12, 16'd7, 1'b1, 1'b0, 1'b0, "sh_c12");
      expect_at(b + 13, 16'd0, 1'b1, 1'b0, 1'b1, "sh_c13");
      expect_at(b + 15, 16'd1, 1'b0, 1'b0, 1'b0, "sh_stop");
      irq_q.push_back(b + 5);
      irq_q.push_back(b + 13);
      pulse(1'b1, 1'b0);
      wait_until(b + 2);
      cfg_period = 16'd7;
      wait_until(b + 14);
      pulse(1'b0, 1'b1);
      wait_until(b + 17);

      // Period 0: irq every cycle with presc 0, count stays 0.
      set_cfg(16'd0, 8'd0, 1'b0);
      b = cyc;
      expect_at(b + 1, 16'd0, 1'b1, 1'b0, 1'b0, "p0_c1");
      expect_at(b + 2, 16'd0, 1'b1, 1'b0, 1'b1, "p0_c2");
      expect_at(b + 4, 16'd0, 1'b1, 1'b0, 1'b1, "p0_c4");
      expect_at(b + 5, 16'd0, 1'b0, 1'b0, 1'b0, "p0_stop");
      irq_q.push_back(b + 2);
      irq_q.push_back(b + 3);
      irq_q.push_back(b + 4);
      pulse(1'b1, 1'b0);
      wait_until(b + 4);
      pulse(1'b0, 1'b1);
      wait_until(b + 7);

      // Reset mid-run for two cycles.
      set_cfg(16'd10, 8'd0, 1'b0);
      b = cyc;
      expect_at(b + 5, 16'd4, 1'b1, 1'b0, 1'b0, "rst_pre");
      expect_at(b + 6, 16'd0, 1'b0, 1'b0, 1'b0, "rst_e1");
      expect_at(b + 7, 16'd0, 1'b0, 1'b0, 1'b0, "rst_e2");
      expect_at(b + 9, 16'd0, 1'b0, 1'b0, 1'b0, "rst_after");
      pulse(1'b1, 1'b0);
      wait_until(b + 5);
      rst_n = 1'b0;
      wait_until(b + 7);
      rst_n = 1'b1;
      wait_until(b + 11);

      check("exp_leftover", 32'(exp_q.size()), 32'(0));
      check("irq_leftover", 32'(irq_q.size()), 32'(0));
      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
